// File: rtl/cu_pkg.sv
// cu_pkg: opcodes, ALU select codes and FSM state encodings for the multicycle controller.
package cu_pkg;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5,
        OP_JMP   = 4'h6,
        OP_BEQ   = 4'h7,
        OP_AND   = 4'h8,
        OP_OR    = 4'h9,
        OP_XOR   = 4'hA,
        OP_BNE   = 4'hB
    } op_e;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_s_e;

    typedef logic [3:0] cu_state_e;

    localparam cu_state_e S_INIT    = 4'd0;
    localparam cu_state_e S_FETCH   = 4'd1;
    localparam cu_state_e S_FETCH_W = 4'd2;
    localparam cu_state_e S_DECODE  = 4'd3;
    localparam cu_state_e S_LD_A    = 4'd4;
    localparam cu_state_e S_LD_B    = 4'd5;
    localparam cu_state_e S_ST      = 4'd6;
    localparam cu_state_e S_ALU     = 4'd7;
    localparam cu_state_e S_JMP     = 4'd8;
    localparam cu_state_e S_BR_CMP  = 4'd9;
    localparam cu_state_e S_BR_RES  = 4'd10;
    localparam cu_state_e S_HALT    = 4'd11;

    function automatic alu_s_e alu_sel(input logic [3:0] op);
        return op == OP_ADD ? ALU_ADD :
               op == OP_SUB ? ALU_SUB :
               op == OP_AND ? ALU_AND :
               op == OP_OR  ? ALU_OR  :
               op == OP_XOR ? ALU_XOR : ALU_PASS;
    endfunction

endpackage

// File: rtl/control_unit_mc_if.sv
// control_unit_mc_if: instruction/flag inputs and registered control strobes between controller and datapath.
interface control_unit_mc_if #(
    parameter int RAW = 4,
    parameter int DAW = 8,
    parameter int OPW = 4,
    parameter int ASW = 4
);
    localparam int IW = OPW + RAW + DAW;

    logic [IW-1:0]  ir;
    logic           alu_z;
    logic           resume;
    logic           pc_clr;
    logic           pc_ic;
    logic           pc_ld;
    logic           pc_add;
    logic [DAW-1:0] pc_tgt;
    logic [RAW-1:0] pc_off;
    logic           ir_ld;
    logic [DAW-1:0] d_addr;
    logic           d_wr;
    logic           rf_s;
    logic           rf_w_en;
    logic [RAW-1:0] rf_a_addr;
    logic [RAW-1:0] rf_b_addr;
    logic [RAW-1:0] rf_w_addr;
    logic [ASW-1:0] alu_s;
    logic           halted;
    logic           illegal;

    modport master (
        input  ir, alu_z, resume,
        output pc_clr, pc_ic, pc_ld, pc_add, pc_tgt, pc_off, ir_ld, d_addr, d_wr,
               rf_s, rf_w_en, rf_a_addr, rf_b_addr, rf_w_addr, alu_s, halted, illegal
    );

    modport slave (
        output ir, alu_z, resume,
        input  pc_clr, pc_ic, pc_ld, pc_add, pc_tgt, pc_off, ir_ld, d_addr, d_wr,
               rf_s, rf_w_en, rf_a_addr, rf_b_addr, rf_w_addr, alu_s, halted, illegal
    );
endinterface

// File: rtl/cu_decode.sv
// cu_decode: maps the opcode field to the state following DECODE and flags undefined opcodes.
module cu_decode
    import cu_pkg::*;
#(
    parameter int OPW = 4
) (
    input  logic [OPW-1:0] op,
    output cu_state_e      next,
    output logic           legal
);
    always_comb begin
        legal = 1'b1;
        case (op)
            OPW'(OP_NOOP):  next = S_FETCH;
            OPW'(OP_LOAD):  next = S_LD_A;
            OPW'(OP_STORE): next = S_ST;
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR), OPW'(OP_XOR):
                            next = S_ALU;
            OPW'(OP_HALT):  next = S_HALT;
            OPW'(OP_JMP):   next = S_JMP;
            OPW'(OP_BEQ), OPW'(OP_BNE):
                            next = S_BR_CMP;
            default: begin
                next  = S_HALT;
                legal = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/control_unit_mc.sv
// control_unit_mc: multicycle fetch/decode/execute sequencer; every control output is a register
// loaded from the current state, so a state's strobes appear during the cycle after it.
module control_unit_mc
    import cu_pkg::*;
#(
    parameter int RAW = 4,
    parameter int DAW = 8,
    parameter int OPW = 4,
    parameter int ASW = 4
) (
    input logic              clk,
    input logic              rst,
    control_unit_mc_if.master bus
);
    localparam int IW = OPW + RAW + DAW;

    if (DAW != 2 * RAW) begin : g_width_check
        $error("control_unit_mc: DAW must equal 2*RAW");
    end

    typedef struct packed {
        logic           pc_clr;
        logic           pc_ic;
        logic           pc_ld;
        logic           pc_add;
        logic [DAW-1:0] pc_tgt;
        logic [RAW-1:0] pc_off;
        logic           ir_ld;
        logic [DAW-1:0] d_addr;
        logic           d_wr;
        logic           rf_s;
        logic           rf_w_en;
        logic [RAW-1:0] rf_a_addr;
        logic [RAW-1:0] rf_b_addr;
        logic [RAW-1:0] rf_w_addr;
        logic [ASW-1:0] alu_s;
        logic           halted;
    } ctrl_t;

    cu_state_e      state, state_n, dec_next;
    ctrl_t          c_q, c_n;
    logic           legal, illegal, taken;
    logic [OPW-1:0] op;
    logic [RAW-1:0] f2, f1, f0;

    assign op = bus.ir[IW-1 -: OPW];
    assign f2 = bus.ir[3*RAW-1 -: RAW];
    assign f1 = bus.ir[2*RAW-1 -: RAW];
    assign f0 = bus.ir[RAW-1:0];
    // Only BEQ/BNE reach BR_RES, so anything that is not BEQ is BNE there.
    assign taken = op == OPW'(OP_BEQ) ? bus.alu_z : !bus.alu_z;

    cu_decode #(.OPW(OPW)) u_decode (
        .op    (op),
        .next  (dec_next),
        .legal (legal)
    );

    always_comb begin
        c_n     = '0;
        state_n = S_INIT;
        case (state)
            S_INIT: begin
                c_n.pc_clr = 1'b1;
                state_n    = S_FETCH;
            end
            S_FETCH: begin
                c_n.ir_ld = 1'b1;
                c_n.pc_ic = 1'b1;
                state_n   = S_FETCH_W;
            end
            S_FETCH_W: state_n = S_DECODE;
            S_DECODE:  state_n = dec_next;
            S_LD_A, S_LD_B: begin
                c_n.d_addr    = {f2, f1};
                c_n.rf_s      = 1'b1;
                c_n.rf_w_addr = f0;
                c_n.rf_w_en   = state == S_LD_B;
                state_n       = state == S_LD_A ? S_LD_B : S_FETCH;
            end
            S_ST: begin
                c_n.d_addr    = {f1, f0};
                c_n.rf_a_addr = f2;
                c_n.d_wr      = 1'b1;
                state_n       = S_FETCH;
            end
            S_ALU: begin
                c_n.rf_a_addr = f2;
                c_n.rf_b_addr = f1;
                c_n.rf_w_addr = f0;
                c_n.rf_w_en   = 1'b1;
                c_n.alu_s     = ASW'(alu_sel(4'(op)));
                state_n       = S_FETCH;
            end
            S_JMP: begin
                c_n.pc_tgt = {f1, f0};
                c_n.pc_ld  = 1'b1;
                state_n    = S_FETCH;
            end
            S_BR_CMP, S_BR_RES: begin
                c_n.rf_a_addr = f2;
                c_n.rf_b_addr = f1;
                c_n.alu_s     = ASW'(ALU_SUB);
                c_n.pc_add    = state == S_BR_RES && taken;
                c_n.pc_off    = state == S_BR_RES && taken ? f0 : '0;
                state_n       = state == S_BR_CMP ? S_BR_RES : S_FETCH;
            end
            S_HALT: begin
                c_n.halted = 1'b1;
                state_n    = bus.resume ? S_FETCH : S_HALT;
            end
            default: state_n = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_INIT;
            c_q     <= '0;
            illegal <= 1'b0;
        end else begin
            state   <= state_n;
            c_q     <= c_n;
            illegal <= illegal | (state == S_DECODE && !legal);
        end
    end

    assign bus.pc_clr    = c_q.pc_clr;
    assign bus.pc_ic     = c_q.pc_ic;
    assign bus.pc_ld     = c_q.pc_ld;
    assign bus.pc_add    = c_q.pc_add;
    assign bus.pc_tgt    = c_q.pc_tgt;
    assign bus.pc_off    = c_q.pc_off;
    assign bus.ir_ld     = c_q.ir_ld;
    assign bus.d_addr    = c_q.d_addr;
    assign bus.d_wr      = c_q.d_wr;
    assign bus.rf_s      = c_q.rf_s;
    assign bus.rf_w_en   = c_q.rf_w_en;
    assign bus.rf_a_addr = c_q.rf_a_addr;
    assign bus.rf_b_addr = c_q.rf_b_addr;
    assign bus.rf_w_addr = c_q.rf_w_addr;
    assign bus.alu_s     = c_q.alu_s;
    assign bus.halted    = c_q.halted;
    assign bus.illegal   = illegal;
endmodule
